// File: rtl/riscv_pkg.sv
// Shared fetch-side constants and types for the core front end.
package riscv_pkg;

    localparam int unsigned XLEN        = 64;
    localparam logic [31:0] HALT_INSTR  = 32'hFFFF_FFFF;
    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        StRun,
        StStop,
        StHalt
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            inv;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO with flush; head is registered storage and stays put until popped.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  rd_ptr_q;
    logic [PW-1:0]  wr_ptr_q;
    logic [CW-1:0]  count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage is not reset; the consumer qualifies the head with count.
    always_ff @(posedge clock) begin
        if (reset && push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Pipelined instruction fetch: in-order requests to variable-latency imem, prefetch queue to decode,
// redirect flush with stale-response discard, halt-word and invalid-address stop.
module fetch_prefetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned    XLEN       = riscv_pkg::XLEN,
    parameter int unsigned    DEPTH      = 4,
    parameter int unsigned    IMEM_WORDS = 256,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [31:0]     dec_instruction,
    output logic [XLEN-1:0] dec_pc,
    output logic            inv_addr,
    output logic            halted
);

    localparam int unsigned     CW         = $clog2(DEPTH) + 1;
    localparam int unsigned     CW1        = CW + 1;
    localparam logic [XLEN-1:0] IMEM_BYTES = XLEN'(IMEM_WORDS) * XLEN'(INSTR_BYTES);

    fetch_state_e    state_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [CW-1:0]   inflight_q;
    logic [CW-1:0]   discard_q;
    logic [CW-1:0]   inflight_d;
    logic [CW-1:0]   count;
    logic            inv_addr_q;
    logic            halted_q;

    fetch_entry_t    head;
    fetch_entry_t    enq_data;
    logic            redirect;
    logic            pc_ok;
    logic            room;
    logic            req_fire;
    logic            take_resp;
    logic            halt_resp;
    logic            inv_enq;
    logic            enq;
    logic            deq;
    logic            head_valid;
    logic            head_inv;
    logic [XLEN-1:0] resp_pc;

    assign redirect = redirect_valid && (state_q != StHalt);
    assign pc_ok    = (fetch_pc_q[1:0] == 2'b00) && (fetch_pc_q < IMEM_BYTES);
    assign room     = (CW1'(inflight_q) + CW1'(count)) < CW1'(DEPTH);

    // Held off during reset so memory (which shares the reset) never sees a request.
    assign imem_req_valid = reset && (state_q == StRun) && pc_ok && room && !redirect;
    assign imem_req_addr  = imem_req_valid ? fetch_pc_q : '0;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Live (non-discarded) requests are the newest ones, so the oldest live PC is derived.
    assign resp_pc    = fetch_pc_q - (XLEN'(inflight_q - discard_q) << 2);
    assign take_resp  = imem_resp_valid && !redirect && (discard_q == '0) && (state_q == StRun);
    assign halt_resp  = take_resp && (imem_resp_data == HALT_INSTR);
    assign inv_enq    = (state_q == StRun) && !redirect && !pc_ok && (inflight_q == '0) &&
                        (count < CW'(DEPTH));
    assign enq        = take_resp || inv_enq;
    assign inflight_d = inflight_q + CW'(req_fire) - CW'(imem_resp_valid);

    always_comb begin
        enq_data = '0;
        if (inv_enq) begin
            enq_data.pc  = fetch_pc_q;
            enq_data.inv = 1'b1;
        end else begin
            enq_data.pc    = resp_pc;
            enq_data.instr = imem_resp_data;
        end
    end

    assign head_valid = (count != '0) && (state_q != StHalt);
    assign head_inv   = head_valid && head.inv;
    assign dec_valid  = head_valid && !head.inv;
    assign deq        = dec_valid && dec_ready;

    assign dec_pc          = dec_valid ? head.pc : '0;
    assign dec_instruction = dec_valid ? head.instr : '0;
    assign inv_addr        = inv_addr_q;
    assign halted          = halted_q;

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clock    (clock),
        .reset    (reset),
        .push     (enq),
        .push_data(enq_data),
        .pop      (deq),
        .flush    (redirect),
        .head     (head),
        .count    (count)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= StRun;
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            inv_addr_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            if (req_fire) fetch_pc_q <= fetch_pc_q + XLEN'(INSTR_BYTES);
            if (imem_resp_valid && (discard_q != '0)) discard_q <= discard_q - 1'b1;

            if (state_q == StRun) begin
                if (halt_resp) begin
                    state_q   <= StStop;
                    discard_q <= inflight_d;
                end else if (inv_enq) begin
                    state_q <= StStop;
                end
            end

            // A response landing in the redirect cycle is already excluded from inflight_d.
            if (redirect) begin
                fetch_pc_q <= redirect_pc;
                discard_q  <= inflight_d;
                state_q    <= StRun;
            end

            if (deq && (head.instr == HALT_INSTR)) begin
                state_q  <= StHalt;
                halted_q <= 1'b1;
            end else if (head_inv && !redirect) begin
                state_q    <= StHalt;
                halted_q   <= 1'b1;
                inv_addr_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Pipelined instruction fetch front end that replaces the combinational PC-indexed fetch.
- Issues in-order requests to a variable-latency instruction memory and buffers returned words in a DEPTH-entry prefetch queue.
- Delivers {pc, instruction} to the decode stage over a valid/ready handshake.
- Handles branch/jump redirects from execute, and detects the halt word and invalid instruction addresses.

Parameters:
XLEN, 64, PC / address width
DEPTH, 4, prefetch queue entries; also the max requests in flight plus entries queued
IMEM_WORDS, 256, instruction memory size in 32-bit words; valid byte addresses are 0 .. IMEM_WORDS*4-4
RESET_PC, 0, PC fetched first after reset

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  XLEN  byte address of request
imem_resp_valid  input  1  response valid; responses return in request order, at least 1 cycle after acceptance
imem_resp_data  input  32  instruction word
redirect_valid  input  1  execute-stage taken branch / next-PC override
redirect_pc  input  XLEN  new fetch PC
dec_valid  output  1  queue head valid to decode
dec_ready  input  1  decode consumes head
dec_instruction  output  32  head instruction
dec_pc  output  XLEN  head PC
inv_addr  output  1  sticky: invalid instruction address reached the head
halted  output  1  sticky: fetch stopped (halt word consumed or inv_addr)

Behaviour:
- Reset (reset==0 at a posedge): all outputs 0; fetch_pc=RESET_PC; queue empty; inflight=0; discard=0; state=RUN.
  - Outstanding memory responses are not tracked across reset; memory shares the same reset.
- States:
  - RUN: normal fetching.
  - STOP: the halt word or an invalid address has been enqueued; no new requests are issued; the queue drains.
  - HALT: halted=1; no requests; dec_valid=0.
- Issue rule (RUN only):
  - imem_req_valid=1 when inflight+count<DEPTH and fetch_pc is valid and no redirect is present this cycle.
  - On acceptance (valid&&ready): inflight++ and fetch_pc+=4 (XLEN wrap, no error on wrap itself).
- Invalid fetch_pc (fetch_pc[1:0]!=0 or fetch_pc>=IMEM_WORDS*4):
  - No memory request is issued.
  - Once inflight==0, enqueue an entry {fetch_pc, 0, inv=1}; go to STOP.
- Response handling:
  - If discard>0: drop the response, discard--, inflight--.
  - Otherwise: enqueue {pc, data, inv=0}, inflight--.
  - If data==32'hFFFFFFFF: go to STOP; all later responses still in flight are discarded.
- Queue and latency:
  - Registered queue, no bypass. Zero-wait memory gives: request accepted cycle N, response N+1, dec_valid N+2.
  - Sustained throughput is 1 instruction/cycle.
- Decode interface:
  - dec_valid = count>0 && head.inv==0 && state!=HALT.
  - Head outputs stay stable while dec_valid && !dec_ready.
- Head with inv=1: inv_addr=1, halted=1, state=HALT the next cycle.
- Halt word: when the FFFFFFFF entry is accepted by decode, halted=1 and state=HALT. Decode is responsible for ending simulation.
- Redirect (any state except HALT):
  - Flush the queue (count=0).
  - discard = inflight minus responses arriving this cycle; a response in the redirect cycle counts as stale.
  - fetch_pc=redirect_pc; state=RUN.
  - No request is issued in the redirect cycle; redirect_pc is requested the next cycle at earliest.
- Redirect together with dec_ready: the head transfer completes first, then the flush.
- Counter widths: inflight, discard and count are each $clog2(DEPTH)+1 bits.
  - Verification must assert no overflow, and that inflight is never decremented on a response while inflight==0.

Decomposition:
- Shared package riscv_pkg:
  - XLEN
  - HALT_INSTR=32'hFFFFFFFF
  - INSTR_BYTES=4
  - fetch state enum {RUN, STOP, HALT}
  - queue entry struct {pc, instr, inv}
- One sub-module: fetch_queue.
  - Synchronous DEPTH-entry FIFO with flush input, count output and stable head.
  - Same clock and reset convention as this block.

Test Plan:
1. Zero-wait memory, dec_ready=1, words at 0x0..0xC = 0x00100093, 0x00200113, 0x002081B3, 0xFFFFFFFF.
   - Required: dec_pc 0,4,8,C on consecutive cycles starting cycle 2 after reset release.
   - Required: halted=1 the cycle after 0xC is accepted; no request to 0x10 delivered.
2. dec_ready=0 for 10 cycles.
   - Required: imem_req_valid drops once inflight+count=4.
   - Required: dec_pc=0 / dec_instruction held constant.
   - Required: release then drains 0,4,8,C in order.
3. 3-cycle memory latency, 2 requests in flight, redirect_pc=0x40.
   - Required: both stale responses dropped.
   - Required: next dec_pc=0x40; next imem_req_addr=0x40 one cycle after redirect.
4. redirect_pc=0x402 (misaligned), and separately 0x400 with IMEM_WORDS=256.
   - Required: no imem request to that address; dec_valid stays 0; inv_addr=1 and halted=1.
5. Redirect in the same cycle as imem_resp_valid and dec_ready=1.
   - Required: the head is transferred.
   - Required: the response is discarded; queue empty next cycle.
6. reset=0 for one cycle with a full queue.
   - Required: dec_valid=0 and inv_addr=0 next cycle.
   - Required: the first request after release is to RESET_PC.
